nanorv32_test_monitor: RTL and testbench

//  Synthesizable, parametrised end-of-test monitor for nanorv32 simulations and FPGA self-test.

---
 rtl/nanorv32_test_monitor.sv | 120 ++++++++++++
 tb/tb_nanorv32_test_monitor.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanorv32_test_monitor.sv
// nanorv32 end-of-test monitor: classifies a run as PASS/FAIL/UNKNOWN/ILLEGAL/TIMEOUT.
// Optional PC history enabled by defining NANORV32_TESTMON_TRACE_EN.
module nanorv32_test_monitor #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] END_PC = ADDR_W'(32'h0000_0100),
    parameter logic [DATA_W-1:0] PASS_SIG = DATA_W'(32'hCAFF_E000),
    parameter logic [DATA_W-1:0] FAIL_SIG = DATA_W'(32'hDEAD_0000),
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W = 32,
    parameter int HIST_DEPTH = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic                          mon_en,
    input  logic                          pc_valid,
    input  logic [ADDR_W-1:0]             pc,
    input  logic [DATA_W-1:0]             a0,
    input  logic                          illegal_instruction,
    output logic                          done,
    output logic                          pass,
    output logic [2:0]                    status,
    output logic [CNT_W-1:0]              cycle_count,
    output logic [CNT_W-1:0]              retire_count,
    input  logic [$clog2(HIST_DEPTH)-1:0] trace_idx,
    output logic [ADDR_W-1:0]             trace_pc
);

    localparam int IDX_W = $clog2(HIST_DEPTH);
    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       ev_status;
    logic [2:0]       status_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retire_q;
    logic             run_active;

    assign run_active = (state_q == S_RUN) && mon_en;

    // Priority-ordered event classification and FSM next state
    always_comb begin
        state_d   = state_q;
        ev_status = 3'd0;
        if (illegal_instruction) begin
            ev_status = 3'd4;
        end else if (pc_valid && (pc == END_PC)) begin
            if (a0 == PASS_SIG)      ev_status = 3'd1;
            else if (a0 == FAIL_SIG) ev_status = 3'd2;
            else                     ev_status = 3'd3;
        end else if (TO_EN && (cycle_q == TO_LAST)) begin
            ev_status = 3'd5;
        end
        unique case (state_q)
            S_IDLE: if (mon_en) state_d = S_RUN;
            S_RUN: begin
                if (!mon_en)               state_d = S_IDLE;
                else if (ev_status != 3'd0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched result and saturating counters
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            status_q <= 3'd0;
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            state_q <= state_d;
            if (run_active) begin
                if (~&cycle_q) cycle_q <= cycle_q + 1'b1;
                if (pc_valid && ~&retire_q) retire_q <= retire_q + 1'b1;
                if (state_d == S_DONE) status_q <= ev_status;
            end
        end
    end

    assign status       = status_q;
    assign done         = (status_q != 3'd0);
    assign pass         = (status_q == 3'd1);
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;

`ifdef NANORV32_TESTMON_TRACE_EN
    logic [ADDR_W-1:0] hist_q [HIST_DEPTH];
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  rd_ptr;

    // Circular history of retired PCs while running
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end else if (run_active && pc_valid) begin
            hist_q[wr_ptr] <= pc;
            wr_ptr         <= wr_ptr + 1'b1;
        end
    end

    assign rd_ptr   = wr_ptr - IDX_W'(1) - trace_idx;
    assign trace_pc = hist_q[rd_ptr];
`else
    logic unused_trace_idx;
    assign unused_trace_idx = ^trace_idx;
    assign trace_pc = '0;
`endif

endmodule

// File: tb/tb_nanorv32_test_monitor.sv
// Randomized self-checking bench for nanorv32_test_monitor.
// Reference model tracks run phase, counts and PC history with plain variables and a queue.
module tb_nanorv32_test_monitor;

    localparam logic [31:0] END_PC = 32'h0000_0100;
    localparam logic [31:0] PASS_SIG = 32'hCAFF_E000;
    localparam logic [31:0] FAIL_SIG = 32'hDEAD_0000;
    localparam int TO = 20;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b1;
    logic        mon_en = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] a0 = '0;
    logic        illegal_instruction = 1'b0;
    logic        done;
    logic        pass;
    logic [2:0]  status;
    logic [31:0] cycle_count;
    logic [31:0] retire_count;
    logic [2:0]  trace_idx = '0;
    logic [31:0] trace_pc;

    int total = 0;
    int bad = 0;

    // model: phase 0 idle, 1 running, 2 finished
    int          m_phase;
    logic [2:0]  m_status;
    logic [31:0] m_cyc;
    logic [31:0] m_ret;
    logic [31:0] m_hist[$];

    nanorv32_test_monitor #(
        .TIMEOUT_CYC(TO),
        .HIST_DEPTH(8)
    ) dut (
        .clk_in(clk_in),
        .rst_n(rst_n),
        .mon_en(mon_en),
        .pc_valid(pc_valid),
        .pc(pc),
        .a0(a0),
        .illegal_instruction(illegal_instruction),
        .done(done),
        .pass(pass),
        .status(status),
        .cycle_count(cycle_count),
        .retire_count(retire_count),
        .trace_idx(trace_idx),
        .trace_pc(trace_pc)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] want_trace(input int idx);
        return (idx < m_hist.size()) ? m_hist[idx] : 32'h0;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom & 32'hFFFF_FFFC;
        if (p == END_PC) p = p ^ 32'h4;
        return p;
    endfunction

    task automatic tick(input bit en, input bit v, input logic [31:0] p,
                        input logic [31:0] a, input bit ill);
        int ev;
        rst_n = 1'b1;
        mon_en = en;
        pc_valid = v;
        pc = p;
        a0 = a;
        illegal_instruction = ill;
        if (m_phase == 0) begin
            if (en) m_phase = 1;
        end else if (m_phase == 1) begin
            if (!en) begin
                m_phase = 0;
            end else begin
                ev = 0;
                if (ill) ev = 4;
                else if (v && p == END_PC)
                    ev = (a == PASS_SIG) ? 1 : (a == FAIL_SIG) ? 2 : 3;
                else if (m_cyc == TO - 1) ev = 5;
                m_cyc++;
                if (v) begin
                    m_ret++;
                    m_hist.push_front(p);
                end
                if (ev != 0) begin
                    m_phase = 2;
                    m_status = 3'(ev);
                end
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mon_en = 1'($urandom);
        pc_valid = 1'($urandom);
        pc = END_PC;
        a0 = PASS_SIG;
        illegal_instruction = 1'($urandom);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        m_phase = 0;
        m_status = 3'd0;
        m_cyc = '0;
        m_ret = '0;
        m_hist.delete();
    endtask

    task automatic run_stream(input string name, input int n);
        bit v;
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            v = 1'($urandom);
            p = ($urandom_range(0, 3) == 0) ? END_PC : rand_pc();
            if (p == END_PC) v = 1'b0;
            tick(1'b1, v, p, $urandom, 1'b0);
            total++;
            if ({done, pass, status, cycle_count, retire_count} !==
                {m_phase == 2, m_status == 3'd1, m_status, m_cyc, m_ret}) begin
                bad++;
                $display("FAIL %s_stream: got %0b %0b %0d %0d %0d want %0b %0b %0d %0d %0d",
                         name, done, pass, status, cycle_count, retire_count,
                         m_phase == 2, m_status == 3'd1, m_status, m_cyc, m_ret);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        trace_idx = 3'($urandom);
        #1;
        total++;
        if ({done, pass, status, cycle_count, retire_count, trace_pc} !== '0) begin
            bad++;
            $display("FAIL reset: got %0b %0b %0d %0d %0d trace=%h want all 0",
                     done, pass, status, cycle_count, retire_count, trace_pc);
        end
    endtask

    task automatic test_idle_ignored();
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, END_PC, PASS_SIG, 1'($urandom));
        total++;
        if ({done, status, cycle_count, retire_count} !== '0) begin
            bad++;
            $display("FAIL idle_ignored: got done=%0b status=%0d cyc=%0d ret=%0d want 0",
                     done, status, cycle_count, retire_count);
        end
    endtask

    task automatic test_end(input string name, input logic [31:0] sig,
                            input logic [2:0] want_st);
        do_reset();
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        run_stream(name, $urandom_range(3, 12));
        tick(1'b1, 1'b1, END_PC, sig, 1'b0);
        total++;
        if ({done, pass, status, cycle_count, retire_count} !==
            {1'b1, want_st == 3'd1, want_st, m_cyc, m_ret}) begin
            bad++;
            $display("FAIL %s_end: got %0b %0b %0d %0d %0d want 1 %0b %0d %0d %0d",
                     name, done, pass, status, cycle_count, retire_count,
                     want_st == 3'd1, want_st, m_cyc, m_ret);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, END_PC, FAIL_SIG, 1'b1);
        total++;
        if ({done, pass, status, cycle_count, retire_count} !==
            {1'b1, want_st == 3'd1, want_st, m_cyc, m_ret}) begin
            bad++;
            $display("FAIL %s_frozen: got %0b %0b %0d %0d %0d want 1 %0b %0d %0d %0d",
                     name, done, pass, status, cycle_count, retire_count,
                     want_st == 3'd1, want_st, m_cyc, m_ret);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        run_stream("illegal", $urandom_range(2, 8));
        tick(1'b1, 1'b1, END_PC, PASS_SIG, 1'b1);
        total++;
        if ({done, pass, status, cycle_count, retire_count} !==
            {1'b1, 1'b0, 3'd4, m_cyc, m_ret}) begin
            bad++;
            $display("FAIL illegal: got %0b %0b %0d %0d %0d want 1 0 4 %0d %0d",
                     done, pass, status, cycle_count, retire_count, m_cyc, m_ret);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        n = 0;
        while (!done && n < 2 * TO) begin
            tick(1'b1, 1'($urandom), rand_pc(), $urandom, 1'b0);
            n++;
        end
        total++;
        if (n !== TO) begin
            bad++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", n, TO);
        end
        total++;
        if ({done, pass, status, cycle_count, retire_count} !==
            {1'b1, 1'b0, 3'd5, 32'(TO), m_ret}) begin
            bad++;
            $display("FAIL timeout: got %0b %0b %0d %0d %0d want 1 0 5 %0d %0d",
                     done, pass, status, cycle_count, retire_count, TO, m_ret);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        run_stream("mid", 5);
        do_reset();
        total++;
        if ({done, pass, status, cycle_count, retire_count} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got %0b %0b %0d %0d %0d want all 0",
                     done, pass, status, cycle_count, retire_count);
        end
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        run_stream("rearm", 6);
        tick(1'b1, 1'b1, END_PC, PASS_SIG, 1'b0);
        total++;
        if ({done, pass, status, cycle_count, retire_count} !==
            {1'b1, 1'b1, 3'd1, m_cyc, m_ret}) begin
            bad++;
            $display("FAIL rearm_pass: got %0b %0b %0d %0d %0d want 1 1 1 %0d %0d",
                     done, pass, status, cycle_count, retire_count, m_cyc, m_ret);
        end
        do_reset();
        total++;
        if ({done, pass, status, cycle_count, retire_count} !== '0) begin
            bad++;
            $display("FAIL reset_after_done: got %0b %0b %0d %0d %0d want all 0",
                     done, pass, status, cycle_count, retire_count);
        end
    endtask

    task automatic test_trace();
        logic [31:0] want;
        do_reset();
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 11; i++) tick(1'b1, 1'b1, 32'(i * 4), $urandom, 1'b0);
        for (int i = 0; i < 8; i++) begin
            trace_idx = 3'(i);
            #1;
`ifdef NANORV32_TESTMON_TRACE_EN
            want = want_trace(i);
`else
            want = 32'h0;
`endif
            total++;
            if (trace_pc !== want) begin
                bad++;
                $display("FAIL trace_idx%0d: got %h want %h", i, trace_pc, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignored();
        test_end("pass", PASS_SIG, 3'd1);
        test_end("fail", FAIL_SIG, 3'd2);
        test_end("unknown", 32'h1234_5678, 3'd3);
        for (int r = 0; r < 4; r++) begin
            logic [31:0] a;
            a = $urandom;
            if (a == PASS_SIG || a == FAIL_SIG) a = a ^ 32'h1;
            test_end("unknown_rand", a, 3'd3);
        end
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_trace();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
